// File: rtl/bypass_ring_fifo.sv
// rtl/bypass_ring_fifo.sv - circular-buffer valid/ready FIFO with count, almost-full and flush
//
// Optional build macro: BYPASS_RING_FIFO_BYPASS_EN (zero-latency pass-through when empty).
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   valid_pre_i, data_pre_i         upstream word offer
//   ready_pre_o                     upstream may push (not full, not flushing)
//   valid_post_o, data_post_o       downstream word offer
//   ready_post_i                    downstream accepts
//   flush_i                         synchronous clear of all contents
//   count_o                         registered occupancy
//   almost_full_o                   count_o >= AFULL_THRESH
module bypass_ring_fifo #(
  parameter int DEPTH        = 6,
  parameter int DATA_WD      = 32,
  parameter int AFULL_THRESH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         valid_pre_i,
  input  logic [DATA_WD-1:0]           data_pre_i,
  output logic                         ready_pre_o,
  output logic                         valid_post_o,
  output logic [DATA_WD-1:0]           data_post_o,
  input  logic                         ready_post_i,
  input  logic                         flush_i,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic                         almost_full_o
);

  localparam int PTR_WD = $clog2(DEPTH);
  localparam int CNT_WD = $clog2(DEPTH + 1);

  logic [DATA_WD-1:0] mem_q [DEPTH];
  logic [PTR_WD-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_WD-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_WD-1:0]  count_q, count_d;

  logic empty, full, push, pop, pass_thru, wr_en, rd_en;

  // Wrap explicitly so any DEPTH works, not only powers of two.
  function automatic logic [PTR_WD-1:0] ptr_inc(input logic [PTR_WD-1:0] p);
    return (p == PTR_WD'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    empty       = (count_q == '0);
    full        = (count_q == CNT_WD'(DEPTH));
    // Deliberately independent of ready_post_i: a full FIFO stalls one cycle
    // even if a pop happens, keeping the upstream ready path registered-only.
    ready_pre_o = ~full & ~flush_i;
    push        = valid_pre_i & ready_pre_o;
`ifdef BYPASS_RING_FIFO_BYPASS_EN
    if (empty && !flush_i) begin
      valid_post_o = valid_pre_i;
      data_post_o  = data_pre_i;
    end else begin
      valid_post_o = ~empty & ~flush_i;
      data_post_o  = mem_q[rd_ptr_q];
    end
    // A word consumed in the same cycle it arrives at an empty FIFO never touches storage.
    pass_thru = empty & ~flush_i & valid_pre_i & ready_post_i;
`else
    valid_post_o = ~empty & ~flush_i;
    data_post_o  = mem_q[rd_ptr_q];
    pass_thru    = 1'b0;
`endif
    pop   = valid_post_o & ready_post_i;
    wr_en = push & ~pass_thru;
    rd_en = pop & ~pass_thru;

    wr_ptr_d = wr_en ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = rd_en ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + CNT_WD'(1);
      2'b01:   count_d = count_q - CNT_WD'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; contents are only visible behind a nonzero count.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= data_pre_i;
    end
  end

  assign count_o       = count_q;
  assign almost_full_o = (count_q >= CNT_WD'(AFULL_THRESH));

endmodule

// File: tb/tb_bypass_ring_fifo.sv
// tb/tb_bypass_ring_fifo.sv - directed self-checking bench for bypass_ring_fifo
module tb_bypass_ring_fifo;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  // DEPTH=6 instance
  logic        v6 = 1'b0, rp6 = 1'b0, fl6 = 1'b0;
  logic [31:0] d6 = '0;
  logic        rdy6, vo6, af6;
  logic [31:0] do6;
  logic [2:0]  cnt6;

  // DEPTH=5 instance
  logic        v5 = 1'b0, rp5 = 1'b0, fl5 = 1'b0;
  logic [7:0]  d5 = '0;
  logic        rdy5, vo5, af5;
  logic [7:0]  do5;
  logic [2:0]  cnt5;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  bypass_ring_fifo #(.DEPTH(6), .DATA_WD(32), .AFULL_THRESH(4)) u_dut6 (
    .clk(clk), .rst_n(rst_n),
    .valid_pre_i(v6), .data_pre_i(d6), .ready_pre_o(rdy6),
    .valid_post_o(vo6), .data_post_o(do6), .ready_post_i(rp6),
    .flush_i(fl6), .count_o(cnt6), .almost_full_o(af6)
  );

  bypass_ring_fifo #(.DEPTH(5), .DATA_WD(8), .AFULL_THRESH(4)) u_dut5 (
    .clk(clk), .rst_n(rst_n),
    .valid_pre_i(v5), .data_pre_i(d5), .ready_pre_o(rdy5),
    .valid_post_o(vo5), .data_post_o(do5), .ready_post_i(rp5),
    .flush_i(fl5), .count_o(cnt5), .almost_full_o(af5)
  );

  task automatic test_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    checks++; if (cnt6 !== 3'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", cnt6); end
    checks++; if (vo6 !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b exp 0", vo6); end
    checks++; if (rdy6 !== 1'b1) begin errors++; $display("FAIL reset_ready got %0b exp 1", rdy6); end
    checks++; if (af6 !== 1'b0) begin errors++; $display("FAIL reset_afull got %0b exp 0", af6); end
    checks++; if (cnt5 !== 3'd0) begin errors++; $display("FAIL reset_count5 got %0d exp 0", cnt5); end
  endtask

  task automatic test_fill_drain();
    rp6 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      v6 = 1'b1;
      d6 = 32'hA0 + 32'(i);
      #1;
      checks++; if (cnt6 !== 3'(i)) begin errors++; $display("FAIL fill_count[%0d] got %0d exp %0d", i, cnt6, i); end
      checks++; if (af6 !== (i >= 4)) begin errors++; $display("FAIL fill_afull[%0d] got %0b exp %0b", i, af6, (i >= 4)); end
      checks++; if (rdy6 !== 1'b1) begin errors++; $display("FAIL fill_ready[%0d] got %0b exp 1", i, rdy6); end
    end
    @(negedge clk);
    v6 = 1'b0;
    #1;
    checks++; if (cnt6 !== 3'd6) begin errors++; $display("FAIL full_count got %0d exp 6", cnt6); end
    checks++; if (rdy6 !== 1'b0) begin errors++; $display("FAIL full_ready got %0b exp 0", rdy6); end
    checks++; if (af6 !== 1'b1) begin errors++; $display("FAIL full_afull got %0b exp 1", af6); end
    rp6 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      checks++; if (vo6 !== 1'b1) begin errors++; $display("FAIL drain_valid[%0d] got %0b exp 1", i, vo6); end
      checks++; if (do6 !== 32'hA0 + 32'(i)) begin errors++; $display("FAIL drain_data[%0d] got %0h exp %0h", i, do6, 32'hA0 + 32'(i)); end
      checks++; if (cnt6 !== 3'(6 - i)) begin errors++; $display("FAIL drain_count[%0d] got %0d exp %0d", i, cnt6, 6 - i); end
      @(negedge clk);
    end
    #1;
    checks++; if (cnt6 !== 3'd0) begin errors++; $display("FAIL drained_count got %0d exp 0", cnt6); end
    checks++; if (vo6 !== 1'b0) begin errors++; $display("FAIL drained_valid got %0b exp 0", vo6); end
    rp6 = 1'b0;
  endtask

  task automatic test_stream_depth5();
    int sent = 0;
    int exp  = 0;
    for (int cyc = 0; cyc < 600 && exp < 40; cyc++) begin
      @(negedge clk);
      v5  = (sent < 40) && ($urandom_range(0, 3) != 0);
      d5  = 8'(sent);
      rp5 = ($urandom_range(0, 3) != 0);
      #1;
      if (vo5 && rp5) begin
        checks++; if (do5 !== 8'(exp)) begin errors++; $display("FAIL stream_data[%0d] got %0d exp %0d", exp, do5, exp); end
        exp++;
      end
      if (v5 && rdy5) sent++;
    end
    @(negedge clk);
    v5 = 1'b0; rp5 = 1'b0;
    checks++; if (exp !== 40) begin errors++; $display("FAIL stream_words got %0d exp 40", exp); end
    #1;
    checks++; if (cnt5 !== 3'd0) begin errors++; $display("FAIL stream_count got %0d exp 0", cnt5); end
  endtask

  task automatic test_flush();
    rp6 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      v6 = 1'b1;
      d6 = 32'h11 * 32'(i + 1);
    end
    @(negedge clk);
    fl6 = 1'b1; v6 = 1'b1; d6 = 32'h99;
    #1;
    checks++; if (cnt6 !== 3'd3) begin errors++; $display("FAIL preflush_count got %0d exp 3", cnt6); end
    checks++; if (rdy6 !== 1'b0) begin errors++; $display("FAIL flush_ready got %0b exp 0", rdy6); end
    checks++; if (vo6 !== 1'b0) begin errors++; $display("FAIL flush_valid got %0b exp 0", vo6); end
    @(negedge clk);
    fl6 = 1'b0; v6 = 1'b0;
    #1;
    checks++; if (cnt6 !== 3'd0) begin errors++; $display("FAIL postflush_count got %0d exp 0", cnt6); end
    checks++; if (af6 !== 1'b0) begin errors++; $display("FAIL postflush_afull got %0b exp 0", af6); end
    @(negedge clk);
    v6 = 1'b1; d6 = 32'h55;
    @(negedge clk);
    v6 = 1'b0;
    #1;
    checks++; if (vo6 !== 1'b1) begin errors++; $display("FAIL flush_next_valid got %0b exp 1", vo6); end
    checks++; if (do6 !== 32'h55) begin errors++; $display("FAIL flush_next_data got %0h exp 55", do6); end
    checks++; if (cnt6 !== 3'd1) begin errors++; $display("FAIL flush_next_count got %0d exp 1", cnt6); end
    rp6 = 1'b1;
    @(negedge clk);
    rp6 = 1'b0;
    #1;
    checks++; if (cnt6 !== 3'd0) begin errors++; $display("FAIL flush_drain_count got %0d exp 0", cnt6); end
  endtask

  task automatic test_bypass();
    @(negedge clk);
    rp6 = 1'b1; v6 = 1'b1; d6 = 32'h77;
    #1;
`ifdef BYPASS_RING_FIFO_BYPASS_EN
    checks++; if (vo6 !== 1'b1) begin errors++; $display("FAIL bypass_valid got %0b exp 1", vo6); end
    checks++; if (do6 !== 32'h77) begin errors++; $display("FAIL bypass_data got %0h exp 77", do6); end
`else
    checks++; if (vo6 !== 1'b0) begin errors++; $display("FAIL nobypass_valid0 got %0b exp 0", vo6); end
`endif
    @(negedge clk);
    v6 = 1'b0;
    #1;
`ifdef BYPASS_RING_FIFO_BYPASS_EN
    checks++; if (cnt6 !== 3'd0) begin errors++; $display("FAIL bypass_count got %0d exp 0", cnt6); end
    checks++; if (vo6 !== 1'b0) begin errors++; $display("FAIL bypass_after_valid got %0b exp 0", vo6); end
`else
    checks++; if (vo6 !== 1'b1) begin errors++; $display("FAIL nobypass_valid1 got %0b exp 1", vo6); end
    checks++; if (do6 !== 32'h77) begin errors++; $display("FAIL nobypass_data got %0h exp 77", do6); end
    checks++; if (cnt6 !== 3'd1) begin errors++; $display("FAIL nobypass_count got %0d exp 1", cnt6); end
`endif
    @(negedge clk);
    rp6 = 1'b0;
    #1;
    checks++; if (cnt6 !== 3'd0) begin errors++; $display("FAIL bypass_end_count got %0d exp 0", cnt6); end
  endtask

  task automatic test_async_reset();
    rp6 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      v6 = 1'b1;
      d6 = 32'hC0 + 32'(i);
    end
    @(negedge clk);
    v6 = 1'b0;
    #1;
    checks++; if (cnt6 !== 3'd4) begin errors++; $display("FAIL prereset_count got %0d exp 4", cnt6); end
    checks++; if (af6 !== 1'b1) begin errors++; $display("FAIL prereset_afull got %0b exp 1", af6); end
    #1;
    rst_n = 1'b0;
    #1;
    checks++; if (cnt6 !== 3'd0) begin errors++; $display("FAIL async_count got %0d exp 0", cnt6); end
    checks++; if (vo6 !== 1'b0) begin errors++; $display("FAIL async_valid got %0b exp 0", vo6); end
    checks++; if (af6 !== 1'b0) begin errors++; $display("FAIL async_afull got %0b exp 0", af6); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    v6 = 1'b1; d6 = 32'h42;
    #1;
    checks++; if (rdy6 !== 1'b1) begin errors++; $display("FAIL postreset_ready got %0b exp 1", rdy6); end
    @(negedge clk);
    v6 = 1'b0;
    #1;
    checks++; if (cnt6 !== 3'd1) begin errors++; $display("FAIL postreset_count got %0d exp 1", cnt6); end
    checks++; if (do6 !== 32'h42) begin errors++; $display("FAIL postreset_data got %0h exp 42", do6); end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_stream_depth5();
    test_flush();
    test_bypass();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
